// File: rtl/weight_bram_loader_pkg.sv
// weight_bram_loader_pkg: shared state encoding and lane geometry for the weight BRAM write/read paths
package weight_bram_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam int NUM_BRAMS_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DW_DEF = 16;
  localparam int IDX_W = $clog2(NUM_BRAMS_DEF);
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/weight_lane_demux.sv
// weight_lane_demux: registered one-hot write strobe with per-lane address/data hold registers
module weight_lane_demux
  import weight_bram_loader_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NUM_BRAMS = NUM_BRAMS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int IW = IDX_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_valid,
  input  logic [IW-1:0]                   lane_idx,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DW-1:0]                   data,
  output logic [NUM_BRAMS-1:0]            w_we,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0] w_addr_wr_flat,
  output logic [NUM_BRAMS*DW-1:0]         w_din_flat
);
  always_ff @(posedge clk)
    if (rst) begin
      w_we <= '0;
      w_addr_wr_flat <= '0;
      w_din_flat <= '0;
    end else begin
      w_we <= wr_valid ? NUM_BRAMS'(1) << lane_idx : '0;
      if (wr_valid) begin
        w_addr_wr_flat[lane_lo(int'(lane_idx), ADDR_WIDTH) +: ADDR_WIDTH] <= addr;
        w_din_flat[lane_lo(int'(lane_idx), DW) +: DW] <= data;
      end
    end
endmodule

// File: rtl/weight_bram_loader.sv
// weight_bram_loader: spreads a weight word stream round-robin over the BRAM lanes' write ports
module weight_bram_loader
  import weight_bram_loader_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NUM_BRAMS = NUM_BRAMS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDR_WIDTH-1:0]                  base_addr,
  input  logic [ADDR_WIDTH:0]                    words_per_bram,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic signed [DW-1:0]                   s_data,
  input  logic                                   s_last,
  output logic [NUM_BRAMS-1:0]                   w_we,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0]        w_addr_wr_flat,
  output logic signed [NUM_BRAMS*DW-1:0]         w_din_flat,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err_early_last,
  output logic                                   err_missing_last
);
  localparam int IW = $clog2(NUM_BRAMS);
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  state_t state, state_n;
  logic [IW-1:0] lane_idx;
  logic [ADDR_WIDTH:0] off, wpb_q;
  logic [ADDR_WIDTH-1:0] base_q, wr_addr;
  logic hs, last_lane, final_w;
  assign hs = s_valid & s_ready;
  assign last_lane = lane_idx == IW'(NUM_BRAMS - 1);
  assign final_w = last_lane && off == wpb_q - ONE;
  assign wr_addr = base_q + off[ADDR_WIDTH-1:0];
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !start ? IDLE : (words_per_bram == '0 ? DONE : LOAD);
      LOAD:    state_n = hs && (final_w || s_last) ? FLUSH : LOAD;
      FLUSH:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    s_ready = state == LOAD;
    busy = state == LOAD || state == FLUSH;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      lane_idx <= '0;
      off <= '0;
      base_q <= '0;
      wpb_q <= '0;
      err_early_last <= 1'b0;
      err_missing_last <= 1'b0;
    end else if (state == IDLE && start) begin
      lane_idx <= '0;
      off <= '0;
      base_q <= base_addr;
      wpb_q <= words_per_bram;
      err_early_last <= 1'b0;
      err_missing_last <= 1'b0;
    end else if (hs) begin
      lane_idx <= lane_idx + 1'b1;
      if (last_lane) off <= off + ONE;
      if (final_w && !s_last) err_missing_last <= 1'b1;
      if (s_last && !final_w) err_early_last <= 1'b1;
    end
  weight_lane_demux #(.DW(DW), .NUM_BRAMS(NUM_BRAMS), .ADDR_WIDTH(ADDR_WIDTH), .IW(IW)) u_demux (
    .clk(clk),
    .rst(rst),
    .wr_valid(hs),
    .lane_idx(lane_idx),
    .addr(wr_addr),
    .data(s_data),
    .w_we(w_we),
    .w_addr_wr_flat(w_addr_wr_flat),
    .w_din_flat(w_din_flat)
  );
endmodule
